// File: rtl/alu.sv
// Two-operand ALU: ADD, SUB, AND and NOT-B with registered result and Z/N/V flags.
// One-cycle latency; reset has priority over the load enable.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [1:0]       ALUop,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             Z,
  output logic             N,
  output logic             V
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_NOT = 2'b11
  } alu_op_t;

  // Signed overflow: operands entering the adder share a sign that the sum does not.
  function automatic logic adder_overflow(input logic a_msb, input logic b_msb,
                                          input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  alu_op_t          op;
  logic             is_sub;
  logic [WIDTH-1:0] b_operand;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] result;
  logic             ovf;

  assign op = alu_op_t'(ALUop);

  // Shared adder: subtraction is Ain + ~Bin + 1.
  always_comb begin
    is_sub    = (op == OP_SUB);
    b_operand = is_sub ? ~Bin : Bin;
    sum       = Ain + b_operand + {{(WIDTH-1){1'b0}}, is_sub};
  end

  // Result and overflow selection.
  always_comb begin
    result = {WIDTH{1'b0}};
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum;
        ovf    = adder_overflow(Ain[WIDTH-1], b_operand[WIDTH-1], sum[WIDTH-1]);
      end
      OP_SUB: begin
        result = sum;
        ovf    = adder_overflow(Ain[WIDTH-1], b_operand[WIDTH-1], sum[WIDTH-1]);
      end
      OP_AND: begin
        result = Ain & Bin;
        ovf    = 1'b0;
      end
      OP_NOT: begin
        result = ~Bin;
        ovf    = 1'b0;
      end
      default: begin
        result = {WIDTH{1'b0}};
        ovf    = 1'b0;
      end
    endcase
  end

  // Result/flag registers; Z=1 at reset keeps flags consistent with out=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= {WIDTH{1'b0}};
      Z   <= 1'b1;
      N   <= 1'b0;
      V   <= 1'b0;
    end else if (en) begin
      out <= result;
      Z   <= (result == {WIDTH{1'b0}});
      N   <= result[WIDTH-1];
      V   <= ovf;
    end else begin
      out <= out;
      Z   <= Z;
      N   <= N;
      V   <= V;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver queues hand-computed expectations,
// a monitor pops and compares one cycle after each issued edge.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [15:0] Ain;
  logic [15:0] Bin;
  logic [1:0]  ALUop;
  logic        en;
  logic [15:0] out;
  logic        Z;
  logic        N;
  logic        V;

  typedef struct {
    logic [15:0] out;
    logic        z;
    logic        n;
    logic        v;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  logic issue_v;
  int   checks;
  int   passes;

  alu #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .Ain(Ain), .Bin(Bin), .ALUop(ALUop),
    .en(en), .out(out), .Z(Z), .N(N), .V(V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge worth of inputs and queue the expected registered state.
  task automatic step(input logic rst, input logic ena, input logic [15:0] a,
                      input logic [15:0] b, input logic [1:0] op,
                      input logic [15:0] e_out, input logic e_z, input logic e_n,
                      input logic e_v, input string name);
    exp_t e;
    @(negedge clk);
    reset = rst; en = ena; Ain = a; Bin = b; ALUop = op;
    issue_v = 1'b1;
    e.out = e_out; e.z = e_z; e.n = e_n; e.v = e_v; e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: after every issued edge, pop one expectation and compare.
  always @(posedge clk) begin
    logic chk;
    exp_t e;
    chk = issue_v;
    #1;
    if (chk) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_underflow: got out=%h Z=%b N=%b V=%b, expected a queued entry",
                 out, Z, N, V);
      end else begin
        e = exp_q.pop_front();
        if (out === e.out && Z === e.z && N === e.n && V === e.v) begin
          passes++;
        end else begin
          $display("FAIL %s: got out=%h Z=%b N=%b V=%b, expected out=%h Z=%b N=%b V=%b",
                   e.name, out, Z, N, V, e.out, e.z, e.n, e.v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; passes = 0; issue_v = 1'b0;
    reset = 1'b0; en = 1'b0; Ain = 16'h0000; Bin = 16'h0000; ALUop = 2'b00;

    //    rst   en    Ain       Bin       op     out       Z     N     V
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, "reset");
    step(1'b0, 1'b0, 16'h1234, 16'h5678, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, "hold0");
    step(1'b0, 1'b0, 16'h7FFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, "hold1");
    step(1'b0, 1'b0, 16'hFFFF, 16'h0006, 2'b11, 16'h0000, 1'b1, 1'b0, 1'b0, "hold2");
    step(1'b0, 1'b1, 16'h0001, 16'h0001, 2'b00, 16'h0002, 1'b0, 1'b0, 1'b0, "add_1_1");
    step(1'b0, 1'b1, 16'hFFFD, 16'h0007, 2'b00, 16'h0004, 1'b0, 1'b0, 1'b0, "add_m3_7");
    step(1'b0, 1'b1, 16'h0002, 16'h0001, 2'b01, 16'h0001, 1'b0, 1'b0, 1'b0, "sub_2_1");
    step(1'b0, 1'b1, 16'hFFF9, 16'hFFF9, 2'b01, 16'h0000, 1'b1, 1'b0, 1'b0, "sub_eq");
    step(1'b0, 1'b1, 16'h0001, 16'h0002, 2'b01, 16'hFFFF, 1'b0, 1'b1, 1'b0, "sub_1_2");
    step(1'b0, 1'b1, 16'h0005, 16'h0006, 2'b10, 16'h0004, 1'b0, 1'b0, 1'b0, "and_5_6");
    step(1'b0, 1'b1, 16'h1234, 16'h0006, 2'b11, 16'hFFF9, 1'b0, 1'b1, 1'b0, "not_6");
    step(1'b0, 1'b1, 16'h7FFF, 16'h0001, 2'b00, 16'h8000, 1'b0, 1'b1, 1'b1, "add_ovf_pos");
    step(1'b0, 1'b1, 16'h8000, 16'h0001, 2'b01, 16'h7FFF, 1'b0, 1'b0, 1'b1, "sub_ovf_neg");
    step(1'b0, 1'b1, 16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, "add_wrap_zero");
    step(1'b0, 1'b1, 16'h8000, 16'h8000, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b1, "add_min_min");
    step(1'b0, 1'b1, 16'h8000, 16'h7FFF, 2'b01, 16'h0001, 1'b0, 1'b0, 1'b1, "sub_min_max");
    step(1'b0, 1'b1, 16'hFFFF, 16'h8000, 2'b10, 16'h8000, 1'b0, 1'b1, 1'b0, "and_msb");
    step(1'b0, 1'b1, 16'h0001, 16'h0001, 2'b00, 16'h0002, 1'b0, 1'b0, 1'b0, "compute_2");
    step(1'b0, 1'b0, 16'hAAAA, 16'h5555, 2'b01, 16'h0002, 1'b0, 1'b0, 1'b0, "en_low_hold");
    step(1'b1, 1'b1, 16'h7FFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, "reset_over_en");
    step(1'b0, 1'b1, 16'h0003, 16'h0004, 2'b00, 16'h0007, 1'b0, 1'b0, 1'b0, "add_after_reset");

    @(negedge clk);
    issue_v = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);

    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
